// File: rtl/usb_bit_stuffer.sv
// Purpose: USB bit stuffer between the CRC stage and NRZI encoder; inserts a 0 after RUN_LEN consecutive 1s.
// Latency: one cycle from accepted in_bit to out_bit/out_valid; each stuffed 0 adds one cycle.
// Backpressure: bs_ready drops for exactly one cycle per stuffed bit, and depends only on state.
module usb_bit_stuffer #(
  parameter int RUN_LEN = 6,  // legal range 2..15; ones_cnt is 4 bits wide
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             bs_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic [CNT_W-1:0] stuff_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PASS  = 2'd1;
  localparam logic [1:0] ST_STUFF = 2'd2;

  localparam logic [3:0]       RUN_LEN4 = 4'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0] state;
  logic [3:0] ones_cnt;
  logic [3:0] ones_inc;
  logic [3:0] ones_first;

  // Upstream is only stalled in the cycle the stuffed 0 is being emitted.
  assign bs_ready = (state != ST_STUFF);

  // Run length after accepting in_bit: mid-packet, and at the first bit of a packet.
  always_comb begin
    ones_inc   = in_bit ? (ones_cnt + 4'd1) : 4'd0;
    ones_first = {3'b000, in_bit};
  end

  // Stuffing state machine, output register and stuffed-bit counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      ones_cnt  <= 4'd0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      stuff_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            // First bit of a new packet: the previous packet's count is dropped here.
            stuff_cnt <= '0;
            ones_cnt  <= ones_first;
            out_bit   <= in_bit;
            out_valid <= 1'b1;
            state     <= (ones_first == RUN_LEN4) ? ST_STUFF : ST_PASS;
          end else begin
            out_valid <= 1'b0;
          end
        end
        ST_PASS: begin
          if (in_valid) begin
            ones_cnt  <= ones_inc;
            out_bit   <= in_bit;
            out_valid <= 1'b1;
            state     <= (ones_inc == RUN_LEN4) ? ST_STUFF : ST_PASS;
          end else begin
            out_valid <= 1'b0;
            ones_cnt  <= 4'd0;
            state     <= ST_IDLE;
          end
        end
        ST_STUFF: begin
          // The stuffed 0 goes out even if the packet ended on the run of 1s.
          out_bit   <= 1'b0;
          out_valid <= 1'b1;
          ones_cnt  <= 4'd0;
          if (stuff_cnt != '1) begin
            stuff_cnt <= stuff_cnt + CNT_ONE;
          end
          state <= in_valid ? ST_PASS : ST_IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          ones_cnt  <= 4'd0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_bit_stuffer.sv
// Purpose: self-checking bench for usb_bit_stuffer with directed and random packets.
// Latency: expects accepted bits one cycle later and one stall cycle per stuffed 0.
// Backpressure: the driver holds each bit until bs_ready accepts it.
module tb_usb_bit_stuffer;

  localparam int RUN_LEN = 6;
  localparam int CNT_W   = 8;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_bit;
  logic             in_valid;
  logic             bs_ready;
  logic             out_bit;
  logic             out_valid;
  logic [CNT_W-1:0] stuff_cnt;

  int checks = 0;
  int errors = 0;

  bit pkt[$];
  bit outq[$];
  int stall_seen = 0;

  always #5 clock = ~clock;

  usb_bit_stuffer #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .bs_ready (bs_ready),
    .out_bit  (out_bit),
    .out_valid(out_valid),
    .stuff_cnt(stuff_cnt)
  );

  // Collect every emitted bit and every stall cycle, sampled away from the rising edge.
  always @(negedge clock) begin
    if (out_valid === 1'b1) outq.push_back(out_bit);
    if (bs_ready === 1'b0) stall_seen++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load pkt from the n low bits of v, MSB sent first.
  task automatic load(input logic [63:0] v, input int n);
    pkt.delete();
    for (int i = n - 1; i >= 0; i--) pkt.push_back(v[i]);
  endtask

  // Drive pkt, then compare the emitted stream against a stuffing model of the bit list.
  task automatic run_packet(input string tag);
    logic [63:0] exp_v;
    logic [63:0] obs_v;
    int exp_len, stuffs, run, base_o, base_s, idx, guard;
    bit acc, first;
    exp_v = '0; exp_len = 0; stuffs = 0; run = 0;
    foreach (pkt[i]) begin
      exp_v = {exp_v[62:0], pkt[i]};
      exp_len++;
      run = pkt[i] ? run + 1 : 0;
      if (run == RUN_LEN) begin
        exp_v = {exp_v[62:0], 1'b0};
        exp_len++;
        stuffs++;
        run = 0;
      end
    end
    base_o = outq.size();
    base_s = stall_seen;
    idx = 0; guard = 0; first = 1'b1;
    in_valid = 1'b1;
    while (idx < pkt.size() && guard < 4 * pkt.size() + 8) begin
      in_bit = pkt[idx];
      acc = bs_ready;
      @(posedge clock); #1;
      guard++;
      if (acc) begin
        if (first) begin
          chk({tag, "_first_bit"}, {62'd0, out_valid, out_bit}, {62'd0, 1'b1, pkt[0]});
          first = 1'b0;
        end
        idx++;
      end
    end
    chk({tag, "_all_accepted"}, 64'(idx), 64'(pkt.size()));
    in_valid = 1'b0;
    in_bit   = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk({tag, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_idle_ready"}, {63'd0, bs_ready}, 64'd1);
    obs_v = '0;
    for (int i = base_o; i < outq.size(); i++) obs_v = {obs_v[62:0], outq[i]};
    chk({tag, "_len"}, 64'(outq.size() - base_o), 64'(exp_len));
    chk({tag, "_stream"}, obs_v, exp_v);
    chk({tag, "_stuff_cnt"}, 64'(stuff_cnt), 64'(stuffs));
    chk({tag, "_stalls"}, 64'(stall_seen - base_s), 64'(stuffs));
  endtask

  initial begin
    int n;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_bit",   {63'd0, out_bit},   64'd0);
    chk("rst_stuff_cnt", 64'(stuff_cnt),     64'd0);
    chk("rst_bs_ready",  {63'd0, bs_ready},  64'd1);
    #12 reset_n = 1'b1;
    @(posedge clock); #1;

    // Stall timing around the sixth accepted 1.
    in_valid = 1'b1;
    in_bit   = 1'b1;
    repeat (6) begin
      chk("run_ready", {63'd0, bs_ready}, 64'd1);
      @(posedge clock); #1;
    end
    chk("t1_out_bit",   {63'd0, out_bit},   64'd1);
    chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_bs_ready",  {63'd0, bs_ready},  64'd0);
    @(posedge clock); #1;
    chk("t2_out_bit",   {63'd0, out_bit},   64'd0);
    chk("t2_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t2_bs_ready",  {63'd0, bs_ready},  64'd1);
    @(posedge clock); #1;
    chk("t3_out_bit", {63'd0, out_bit}, 64'd1);
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("timing_stuff_cnt", 64'(stuff_cnt), 64'd1);

    load(64'b0101_0101, 8);   run_packet("alt");
    load(64'hFF, 8);          run_packet("ones8");
    load(64'h3F, 6);          run_packet("ones6");
    load(64'hFFF, 12);        run_packet("ones12");

    // Asynchronous reset in the middle of a cycle while stuff_cnt holds 2.
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_out_bit",   {63'd0, out_bit},   64'd0);
    chk("mid_rst_stuff_cnt", 64'(stuff_cnt),     64'd0);
    chk("mid_rst_bs_ready",  {63'd0, bs_ready},  64'd1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    load(64'b11111_0_11111, 11); run_packet("run5");

    // Reset landing in the stall cycle abandons the stuffed 0.
    in_valid = 1'b1;
    in_bit   = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    chk("stf_pre_ready", {63'd0, bs_ready}, 64'd0);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    #1;
    chk("stf_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("stf_rst_ready", {63'd0, bs_ready},  64'd1);
    repeat (2) @(posedge clock);
    #1;
    chk("stf_rst_no_stuff", {63'd0, out_valid}, 64'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    load(64'b000, 3); run_packet("zeros");

    // Random packets biased toward long runs of 1s.
    for (int p = 0; p < 20; p++) begin
      n = $urandom_range(1, 40);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(bit'($urandom_range(0, 4) != 0));
      run_packet("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
